instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 68 ++++++
 rtl/instr_fetch_unit_buffer.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit_pkg                                         |
// | Description : Shared types and helpers for the PDP-11 instruction fetch    |
// |               stage: fetch FSM state encoding, the buffer entry record,    |
// |               addressing-mode constants and the extension-word counter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package instr_fetch_unit_pkg;

    // Addressing-mode constants for a 6-bit operand field {mode[2:0], reg[2:0]}
    localparam logic [2:0] PC_REG           = 3'd7;
    localparam logic [2:0] MODE_INDEX       = 3'd6;
    localparam logic [2:0] MODE_INDEX_DEF   = 3'd7;
    localparam logic [2:0] MODE_AUTOINC     = 3'd2;  // (PC)+ is immediate
    localparam logic [2:0] MODE_AUTOINC_DEF = 3'd3;  // @(PC)+ is absolute

    // Fetch FSM: LO issues the even byte, HI captures it and issues the odd
    // byte, CAP captures the odd byte and writes the assembled word.
    typedef enum logic [1:0] {
        LO  = 2'd0,
        HI  = 2'd1,
        CAP = 2'd2
    } fetch_state_t;

    // One output-buffer entry
    typedef struct packed {
        logic [15:0] word;
        logic [15:0] pc;
        logic        is_ext;
    } fetch_entry_t;

    // 1 if this operand field pulls an extension word from the stream
    function automatic logic [1:0] field_ext(input logic [5:0] f);
        logic [2:0] mode;
        logic [2:0] rnum;
        logic       hit;
        mode = f[5:3];
        rnum = f[2:0];
        hit  = (mode == MODE_INDEX) || (mode == MODE_INDEX_DEF) ||
               ((rnum == PC_REG) &&
                ((mode == MODE_AUTOINC) || (mode == MODE_AUTOINC_DEF)));
        return hit ? 2'd1 : 2'd0;
    endfunction

    // Number of extension words following opcode w (0..2).
    // The decode order matters: 07xxxx and 17xxxx are special-cased before
    // the generic double-operand test on w[14:12].
    function automatic logic [1:0] ext_words(input logic [15:0] w);
        logic [1:0] n;
        n = 2'd0;
        if (w[15:12] == 4'b0111) begin
            // Register-source group; SOB carries a displacement, not a field
            if (w[11:9] != 3'd7) begin
                n = field_ext(w[5:0]);
            end
        end else if (w[15:12] == 4'b1111) begin
            n = 2'd0;
        end else if (w[14:12] != 3'b000) begin
            n = field_ext(w[11:6]) + field_ext(w[5:0]);
        end else if (w[14:11] == 4'b0001) begin
            n = field_ext(w[5:0]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_buffer                                                 |
// | Description : Two-entry FIFO between fetch and decode. The head entry is   |
// |               held in its own register so the decode-facing outputs come   |
// |               straight from flops. Push and pop may coincide at any        |
// |               occupancy; flush empties it and voids a same-cycle pop.      |
// | Ports       : clk, reset_n (sync, active-low), flush, wr_en/wr_data,       |
// |               rd_valid/rd_ready/rd_data (head), count (occupancy)          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_buffer
    import instr_fetch_unit_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         wr_en,
    input  fetch_entry_t wr_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output fetch_entry_t rd_data,
    output logic [1:0]   count
);

    logic [1:0]   r_count;
    fetch_entry_t r_head;
    fetch_entry_t r_tail;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == 2'(BUF_DEPTH));
    assign w_pop  = (r_count != 2'd0) && rd_ready;
    // A write into a full buffer is only accepted when the head leaves
    assign w_push = wr_en && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            // Head refills from the tail when two are held, otherwise from
            // the incoming word when the head slot is (or becomes) free.
            if (w_pop && (r_count == 2'd2)) begin
                r_head <= r_tail;
            end else if (w_push && ((r_count == 2'd0) ||
                                    ((r_count == 2'd1) && w_pop))) begin
                r_head <= wr_data;
            end

            if (w_push && (((r_count == 2'd1) && !w_pop) ||
                           ((r_count == 2'd2) && w_pop))) begin
                r_tail <= wr_data;
            end

            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign rd_valid = (r_count != 2'd0);
    assign rd_data  = r_head;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : PDP-11 instruction fetch. Reads byte-wide flash two bytes    |
// |               per word (little-endian), tags each word as opcode or        |
// |               extension word, and hands words to decode through a 2-entry  |
// |               buffer. Owns the fetch PC; branch redirect flushes/restarts. |
// | Ports       : clk, reset_n (sync, active-low)                              |
// |               flash_rd/flash_addr/flash_rdata  byte flash, 1-cycle data    |
// |               halt                             blocks new word reads       |
// |               redirect/redirect_pc             branch restart              |
// |               instr_valid/ready/word/pc/is_ext decode handshake            |
// |               fetch_pc                         next word to be fetched     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int FLASH_AW  = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                flash_rd,
    output logic [FLASH_AW-1:0] flash_addr,
    input  logic [7:0]          flash_rdata,
    input  logic                halt,
    input  logic                redirect,
    input  logic [15:0]         redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [15:0]         instr_word,
    output logic [15:0]         instr_pc,
    output logic                instr_is_ext,
    output logic [15:0]         fetch_pc
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [15:0]  r_fetch_pc;
    logic [7:0]   r_lo_byte;
    logic [1:0]   r_ext_rem;

    logic         w_flush;
    logic         w_rd;
    logic [15:0]  w_rd_addr;
    logic         w_wr;
    logic         w_issue_lo;
    logic         w_issue_cap;
    logic [15:0]  w_pc_plus2;
    logic [15:0]  w_word;
    logic         w_is_ext;
    logic [1:0]   w_count;
    logic         w_head_valid;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;
    logic         w_unused_pc_bit0;

    // Redirect target is always word-aligned
    assign w_unused_pc_bit0 = redirect_pc[0];

    // Reset behaves as a redirect to PC 0; both kill any word in flight
    assign w_flush    = !reset_n || redirect;
    assign w_pc_plus2 = r_fetch_pc + 16'd2;

    // A new word may start only if every word already started still has a
    // buffer slot. From LO nothing is in flight; from CAP the word being
    // captured has not reached the buffer yet, so it counts against space.
    assign w_issue_lo  = !halt && (w_count < 2'(BUF_DEPTH));
    assign w_issue_cap = !halt && (({1'b0, w_count} + 3'd1) < 3'(BUF_DEPTH));

    // Low byte came back during HI; the high byte is on the bus during CAP
    assign w_word   = {flash_rdata, r_lo_byte};
    assign w_is_ext = (r_ext_rem != 2'd0);
    assign w_entry  = '{word: w_word, pc: r_fetch_pc, is_ext: w_is_ext};

    // ------------------------------------------------------------------
    // Next-state and flash strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_rd         = 1'b0;
        w_rd_addr    = r_fetch_pc;
        w_wr         = 1'b0;

        case (r_state)
            LO: begin
                if (w_issue_lo) begin
                    w_rd         = 1'b1;
                    w_next_state = HI;
                end
            end
            HI: begin
                // Once the even byte is out the word always completes
                w_rd         = 1'b1;
                w_rd_addr    = r_fetch_pc + 16'd1;
                w_next_state = CAP;
            end
            CAP: begin
                // Overlapped LO of the following word
                w_wr      = 1'b1;
                w_rd_addr = w_pc_plus2;
                if (w_issue_cap) begin
                    w_rd         = 1'b1;
                    w_next_state = HI;
                end else begin
                    w_next_state = LO;
                end
            end
            default: begin
                w_next_state = LO;
            end
        endcase

        // A read issued now would return into a flushed pipeline
        if (w_flush) begin
            w_rd         = 1'b0;
            w_wr         = 1'b0;
            w_next_state = LO;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= LO;
            r_fetch_pc <= 16'h0000;
            r_lo_byte  <= 8'h00;
            r_ext_rem  <= 2'd0;
        end else if (redirect) begin
            r_state    <= LO;
            r_fetch_pc <= {redirect_pc[15:1], 1'b0};
            r_lo_byte  <= 8'h00;
            r_ext_rem  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == HI) begin
                r_lo_byte <= flash_rdata;
            end
            if (w_wr) begin
                // Wraps FFFE -> 0000 naturally
                r_fetch_pc <= w_pc_plus2;
                // An opcode arms the counter; extension words drain it
                if (r_ext_rem == 2'd0) begin
                    r_ext_rem <= ext_words(w_word);
                end else begin
                    r_ext_rem <= r_ext_rem - 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect),
        .wr_en    (w_wr),
        .wr_data  (w_entry),
        .rd_ready (instr_ready),
        .rd_valid (w_head_valid),
        .rd_data  (w_head),
        .count    (w_count)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign flash_rd     = w_rd;
    assign flash_addr   = FLASH_AW'(w_rd_addr);
    assign instr_valid  = w_head_valid;
    assign instr_word   = w_head.word;
    assign instr_pc     = w_head.pc;
    assign instr_is_ext = w_head.is_ext;
    assign fetch_pc     = r_fetch_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Scoreboard bench for instr_fetch_unit with a byte flash      |
// |               model. Stimulus pushes expected words; a negedge monitor     |
// |               pops and compares on every decode handshake.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flash_rd;
    logic [15:0] flash_addr;
    logic [7:0]  flash_rdata = 8'h00;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word;
    logic [15:0] instr_pc;
    logic        instr_is_ext;
    logic [15:0] fetch_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .FLASH_AW  (16),
        .BUF_DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flash_rd     (flash_rd),
        .flash_addr   (flash_addr),
        .flash_rdata  (flash_rdata),
        .halt         (halt),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_word   (instr_word),
        .instr_pc     (instr_pc),
        .instr_is_ext (instr_is_ext),
        .fetch_pc     (fetch_pc)
    );

    // Flash: data appears the cycle after the strobe
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (flash_rd) flash_rdata <= mem[flash_addr];
    end

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q [$];
    logic [32:0] mon_exp;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] w, input logic [15:0] p, input logic e);
        exp_q.push_back({w, p, e});
    endtask

    // Monitor: a handshake is pending at the next edge when valid && ready
    always @(negedge clk) begin
        if (reset_n && !redirect && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: actual word=%h pc=%h ext=%b required=no word",
                         instr_word, instr_pc, instr_is_ext);
            end else begin
                mon_exp = exp_q.pop_front();
                check($sformatf("word@%h", mon_exp[16:1]),
                      {instr_word, instr_pc, instr_is_ext}, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        tick();
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    // Accept exactly k words, then drop ready
    task automatic consume(input int k);
        int n = 0;
        int t = 0;
        tick();
        instr_ready = 1'b1;
        while ((n < k) && (t < 200)) begin
            @(negedge clk);
            #1;
            if (instr_valid && instr_ready) n++;
            if (n == k) tick();
            t++;
        end
        instr_ready = 1'b0;
        check("consume_count", 33'(n), 33'(k));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_seen;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        // MOV #1234, R1 ; CLR R0
        mem[16'h0000] = 8'hC1; mem[16'h0001] = 8'h15;
        mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;
        mem[16'h0004] = 8'h00; mem[16'h0005] = 8'h0A;
        // 1DF7 takes two extension words
        mem[16'h0100] = 8'hF7; mem[16'h0101] = 8'h1D;
        mem[16'h0102] = 8'h11; mem[16'h0103] = 8'h11;
        mem[16'h0104] = 8'h22; mem[16'h0105] = 8'h22;
        mem[16'h0106] = 8'h00; mem[16'h0107] = 8'h0A;
        // CLR R0..R3
        mem[16'h0200] = 8'h00; mem[16'h0201] = 8'h0A;
        mem[16'h0202] = 8'h01; mem[16'h0203] = 8'h0A;
        mem[16'h0204] = 8'h02; mem[16'h0205] = 8'h0A;
        mem[16'h0206] = 8'h03; mem[16'h0207] = 8'h0A;
        mem[16'h0300] = 8'hAA; mem[16'h0301] = 8'hBB;
        mem[16'hFFFE] = 8'h05; mem[16'hFFFF] = 8'h0A;

        reset_n     = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        instr_ready = 1'b0;

        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flash", 33'({flash_rd, flash_addr}), 33'h0);
        check("rst_head", {instr_valid, instr_word, instr_pc}, 33'h0);
        check("rst_is_ext", 33'(instr_is_ext), 33'h0);
        check("rst_fetch_pc", 33'(fetch_pc), 33'h0);

        // ---- first fetch latency: cycle 0 starts here
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("c0_rd", 33'({flash_rd, flash_addr}), 33'({1'b1, 16'h0000}));
        check("c0_valid", 33'(instr_valid), 33'h0);
        @(negedge clk);
        check("c1_rd", 33'({flash_rd, flash_addr}), 33'({1'b1, 16'h0001}));
        check("c1_valid", 33'(instr_valid), 33'h0);
        @(negedge clk);
        check("c2_rd", 33'({flash_rd, flash_addr}), 33'({1'b1, 16'h0002}));
        check("c2_valid", 33'(instr_valid), 33'h0);
        @(negedge clk);
        check("c3_valid", 33'(instr_valid), 33'h1);
        check("c3_fetch_pc", 33'(fetch_pc), 33'h0002);
        push(16'h15C1, 16'h0000, 1'b0);
        push(16'h1234, 16'h0002, 1'b1);
        push(16'h0A00, 16'h0004, 1'b0);
        consume(3);
        check("q_empty_basic", 33'(exp_q.size()), 33'h0);

        // ---- two extension words
        redirect_to(16'h0100);
        push(16'h1DF7, 16'h0100, 1'b0);
        push(16'h1111, 16'h0102, 1'b1);
        push(16'h2222, 16'h0104, 1'b1);
        push(16'h0A00, 16'h0106, 1'b0);
        consume(4);
        check("q_empty_ext", 33'(exp_q.size()), 33'h0);

        // ---- decode stalled: buffer fills to 2 then reads stop
        redirect_to(16'h0200);
        rd_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((i >= 6) && flash_rd) rd_seen++;
        end
        check("stall_no_rd", 33'(rd_seen), 33'h0);
        check("stall_valid", 33'(instr_valid), 33'h1);
        check("stall_fetch_pc", 33'(fetch_pc), 33'h0204);
        push(16'h0A00, 16'h0200, 1'b0);
        push(16'h0A01, 16'h0202, 1'b0);
        push(16'h0A02, 16'h0204, 1'b0);
        push(16'h0A03, 16'h0206, 1'b0);
        consume(4);
        check("q_empty_stall", 33'(exp_q.size()), 33'h0);

        // ---- redirect while the high byte is in flight
        redirect_to(16'h0300);
        @(negedge clk);
        check("old_lo_rd", 33'({flash_rd, flash_addr}), 33'({1'b1, 16'h0300}));
        tick();
        @(negedge clk);
        check("old_hi_rd", 33'({flash_rd, flash_addr}), 33'({1'b1, 16'h0301}));
        redirect_to(16'h0101);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) check("redir_rd", 33'({flash_rd, flash_addr}), 33'({1'b1, 16'h0100}));
            check($sformatf("redir_valid_%0d", i), 33'(instr_valid), (i == 4) ? 33'h1 : 33'h0);
        end
        push(16'h1DF7, 16'h0100, 1'b0);
        push(16'h1111, 16'h0102, 1'b1);
        consume(2);
        check("q_empty_redir", 33'(exp_q.size()), 33'h0);

        // ---- halt during LO, then halt raised during HI
        tick();
        halt = 1'b1;
        redirect_to(16'h0200);
        rd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (flash_rd) rd_seen++;
        end
        check("halt_lo_no_rd", 33'(rd_seen), 33'h0);
        check("halt_lo_valid", 33'(instr_valid), 33'h0);
        tick();
        halt = 1'b0;
        @(negedge clk);
        check("halt_lo_issue", 33'({flash_rd, flash_addr}), 33'({1'b1, 16'h0200}));
        tick();
        halt = 1'b1;
        @(negedge clk);
        check("halt_hi_issue", 33'({flash_rd, flash_addr}), 33'({1'b1, 16'h0201}));
        rd_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (flash_rd) rd_seen++;
        end
        check("halt_hi_no_rd", 33'(rd_seen), 33'h0);
        check("halt_hi_valid", 33'(instr_valid), 33'h1);
        push(16'h0A00, 16'h0200, 1'b0);
        consume(1);
        @(negedge clk);
        check("halt_one_word", 33'(instr_valid), 33'h0);
        check("halt_fetch_pc", 33'(fetch_pc), 33'h0202);
        tick();
        halt = 1'b0;

        // ---- PC wrap, odd redirect target forced even
        redirect_to(16'hFFFF);
        push(16'h0A05, 16'hFFFE, 1'b0);
        push(16'h15C1, 16'h0000, 1'b0);
        push(16'h1234, 16'h0002, 1'b1);
        consume(3);
        check("q_empty_wrap", 33'(exp_q.size()), 33'h0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
